// File: rtl/cci_mpf_shim_pkg.sv
// Shared types for the lockstep c0/c1 Tx buffer shim.
// QoS settings bundle plus packet and config FSM encodings.
package cci_mpf_shim_pkg;

  typedef struct packed {
    logic       enable;
    logic [7:0] beat_delta;
    logic [7:0] min_beat;
  } t_qos_cfg;

  typedef enum logic {
    PKT_IDLE,
    PKT_WR
  } t_pkt_state;

  typedef enum logic [1:0] {
    CFG_INIT,
    CFG_PUSH,
    CFG_IDLE
  } t_cfg_state;

  localparam int QOS_CFG_W = $bits(t_qos_cfg);

endpackage

// File: rtl/cci_mpf_shim_lockstep_qos_cfg.sv
// QoS shadow registers and the sequencer that pushes them
// to the buffer's setqos port after reset and on CSR writes.
module cci_mpf_shim_lockstep_qos_cfg
  import cci_mpf_shim_pkg::*;
#(
  parameter int DEF_QOS_ENABLE = 1,
  parameter int DEF_BEAT_DELTA = 6,
  parameter int DEF_MIN_BEAT   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 csr_qos_wr,
  input  logic [QOS_CFG_W-1:0] csr_qos_data,
  output logic                 setqos,
  output t_qos_cfg             cfg
);

  localparam t_qos_cfg DEF_CFG = '{
    enable:     1'(DEF_QOS_ENABLE),
    beat_delta: 8'(DEF_BEAT_DELTA),
    min_beat:   8'(DEF_MIN_BEAT)
  };

  t_cfg_state state_q, state_d;
  t_qos_cfg   shadow_q, shadow_d;
  logic       hold_q, hold_d;

  // hold_q keeps INIT for one cycle past reset so the
  // default push lands two cycles after release
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    hold_d   = 1'b0;
    setqos   = 1'b0;
    case (state_q)
      CFG_INIT: begin
        if (!hold_q) state_d = CFG_PUSH;
      end
      CFG_PUSH: begin
        setqos  = !reset;
        state_d = CFG_IDLE;
      end
      CFG_IDLE: begin
        state_d = CFG_IDLE;
      end
      default: begin
        state_d = CFG_INIT;
      end
    endcase
    if (csr_qos_wr) begin
      shadow_d = t_qos_cfg'(csr_qos_data);
      state_d  = CFG_PUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CFG_INIT;
      shadow_q <= DEF_CFG;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      hold_q   <= hold_d;
    end
  end

  assign cfg = shadow_q;

endmodule

// File: rtl/cci_mpf_shim_lockstep_tx_sched.sv
// Lockstep c0/c1 Tx dequeue scheduler: issues deqTx,
// tracks write packets, counts stalls, drives QoS config.
module cci_mpf_shim_lockstep_tx_sched
  import cci_mpf_shim_pkg::*;
#(
  parameter int MAX_STALL_CYCLES = 1023,
  parameter int DEF_QOS_ENABLE   = 1,
  parameter int DEF_BEAT_DELTA   = 6,
  parameter int DEF_MIN_BEAT     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        head_c0_valid,
  input  logic        head_c1_valid,
  input  logic        head_c1_sop,
  input  logic [1:0]  head_c1_cl_len,
  input  logic        fiu_c0_almfull,
  input  logic        fiu_c1_almfull,
  input  logic        csr_qos_wr,
  input  logic [16:0] csr_qos_data,
  output logic        deqTx,
  output logic        setqos,
  output logic        setqos_enable,
  output logic [7:0]  setqos_beat_delta_threshold,
  output logic [7:0]  setqos_min_beat_threshold,
  output logic        in_wr_packet,
  output logic        stall_timeout,
  output logic        pkt_error,
  output logic [15:0] stall_cycles
);

  logic head_any;
  logic c0_blk;
  logic c1_blk;
  logic c1_deq;

  assign head_any = head_c0_valid | head_c1_valid;
  assign c0_blk   = head_c0_valid & fiu_c0_almfull;
  assign c1_blk   = head_c1_valid & fiu_c1_almfull;
  assign deqTx    = head_any & !c0_blk & !c1_blk & !reset;
  assign c1_deq   = deqTx & head_c1_valid;

  t_pkt_state  pkt_state_q, pkt_state_d;
  logic [1:0]  beats_left_q, beats_left_d;
  logic        pkt_error_q, pkt_error_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        stall_timeout_q, stall_timeout_d;
  logic        in_wr;

  assign in_wr = (pkt_state_q == PKT_WR);

  // A protocol error restarts tracking from the offending beat
  always_comb begin
    pkt_state_d  = pkt_state_q;
    beats_left_d = beats_left_q;
    pkt_error_d  = pkt_error_q;
    if (c1_deq) begin
      if (in_wr == head_c1_sop) pkt_error_d = 1'b1;
      if (in_wr && !head_c1_sop) begin
        beats_left_d = beats_left_q - 2'd1;
        if (beats_left_q == 2'd1) pkt_state_d = PKT_IDLE;
      end else if (head_c1_sop && head_c1_cl_len != 2'd0) begin
        pkt_state_d  = PKT_WR;
        beats_left_d = head_c1_cl_len;
      end else begin
        pkt_state_d  = PKT_IDLE;
        beats_left_d = 2'd0;
      end
    end
  end

  always_comb begin
    stall_cycles_d  = 16'd0;
    stall_timeout_d = stall_timeout_q;
    if (head_any && !deqTx) begin
      stall_cycles_d = stall_cycles_q;
      if (stall_cycles_q != 16'hFFFF)
        stall_cycles_d = stall_cycles_q + 16'd1;
    end
    if (stall_cycles_q == 16'(MAX_STALL_CYCLES))
      stall_timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_state_q     <= PKT_IDLE;
      beats_left_q    <= 2'd0;
      pkt_error_q     <= 1'b0;
      stall_cycles_q  <= 16'd0;
      stall_timeout_q <= 1'b0;
    end else begin
      pkt_state_q     <= pkt_state_d;
      beats_left_q    <= beats_left_d;
      pkt_error_q     <= pkt_error_d;
      stall_cycles_q  <= stall_cycles_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign in_wr_packet  = in_wr;
  assign pkt_error     = pkt_error_q;
  assign stall_cycles  = stall_cycles_q;
  assign stall_timeout = stall_timeout_q;

  t_qos_cfg qos_cfg;

  cci_mpf_shim_lockstep_qos_cfg #(
    .DEF_QOS_ENABLE (DEF_QOS_ENABLE),
    .DEF_BEAT_DELTA (DEF_BEAT_DELTA),
    .DEF_MIN_BEAT   (DEF_MIN_BEAT)
  ) u_qos_cfg (
    .clk          (clk),
    .reset        (reset),
    .csr_qos_wr   (csr_qos_wr),
    .csr_qos_data (csr_qos_data),
    .setqos       (setqos),
    .cfg          (qos_cfg)
  );

  assign setqos_enable               = qos_cfg.enable;
  assign setqos_beat_delta_threshold = qos_cfg.beat_delta;
  assign setqos_min_beat_threshold   = qos_cfg.min_beat;

endmodule
